// File: rtl/dt_pkg.sv
// dt_pkg: shared image geometry, FSM states and neighbour offsets for the distance-transform passes
package dt_pkg;
  localparam int DT_IMG_W = 128;
  localparam int DT_IMG_H = 128;
  localparam int DT_OFF_NW = DT_IMG_W + 1;
  localparam int DT_OFF_N  = DT_IMG_W;
  localparam int DT_OFF_NE = DT_IMG_W - 1;
  localparam int DT_OFF_W  = 1;
  typedef enum logic [3:0] {IDLE, RD_C, RD_NW, RD_N, RD_NE, RD_W, CMP, WR, NXT, DONE} dt_state_e;
  // Amount subtracted from the centre address for the pixel read in state s (image width w).
  function automatic int nb_off(input dt_state_e s, input int w);
    return s == RD_NW ? w + 1 : s == RD_N ? w : s == RD_NE ? w - 1 : s == RD_W ? 1 : 0;
  endfunction
endpackage

// File: rtl/dt_min4.sv
// dt_min4: combinational minimum of four DW-bit values (two-level compare tree)
//   a,b,c,d in DW ; y out DW = min(a,b,c,d)
module dt_min4 #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] y
);
  logic [DW-1:0] ab, cd;
  assign ab = a < b ? a : b;
  assign cd = c < d ? c : d;
  assign y  = ab < cd ? ab : cd;
endmodule

// File: rtl/dt_forward_pass.sv
// dt_forward_pass: raster-order chessboard distance-transform pass over the res RAM image
//   clk, rstn (async active-low), start (level, sampled in IDLE)
//   res_rd/res_addr/res_di: RAM read, data valid the cycle after the strobe
//   res_wr/res_do: single-cycle RAM write at the shared res_addr
//   fwd_done: held high once the scan completes
//   DT_FWD_STATS_EN: adds obj_cnt, the number of object pixels written
module dt_forward_pass
  import dt_pkg::*;
#(
  parameter int IMG_W = DT_IMG_W,
  parameter int IMG_H = DT_IMG_H,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          res_rd,
  output logic [AW-1:0] res_addr,
  input  logic [DW-1:0] res_di,
  output logic          res_wr,
  output logic [DW-1:0] res_do,
  output logic          fwd_done
`ifdef DT_FWD_STATS_EN
  ,
  output logic [AW-1:0] obj_cnt
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = AW - CW;
  dt_state_e state, nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [DW-1:0] nw, n, ne, m, m4;
  logic [AW-1:0] ctr;
  logic last, row_end;
  assign ctr      = {row, col};
  assign row_end  = col == CW'(IMG_W - 2);
  assign last     = row == RW'(IMG_H - 2) && row_end;
  assign fwd_done = state == DONE;
  // W arrives on res_di during CMP, so it feeds the min tree directly.
  dt_min4 #(.DW(DW)) u_min4 (.a(nw), .b(n), .c(ne), .d(res_di), .y(m4));
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      row   <= RW'(1);
      col   <= CW'(1);
      nw    <= '0;
      n     <= '0;
      ne    <= '0;
      m     <= '0;
    end else begin
      state <= nxt;
      if (state == RD_N) nw <= res_di;
      if (state == RD_NE) n <= res_di;
      if (state == RD_W) ne <= res_di;
      if (state == CMP) m <= m4;
      if (state == NXT && !last) begin
        col <= row_end ? CW'(1) : col + 1'b1;
        if (row_end) row <= row + 1'b1;
      end
    end
  end
  always_comb begin
    nxt      = state;
    res_rd   = 1'b0;
    res_wr   = 1'b0;
    res_do   = '0;
    res_addr = state inside {RD_C, RD_NW, RD_N, RD_NE, RD_W, WR} ? ctr - AW'(nb_off(state, IMG_W)) : '0;
    case (state)
      IDLE:  nxt = start ? RD_C : IDLE;
      RD_C:  begin res_rd = 1'b1; nxt = RD_NW; end
      // res_di holds the centre here; background pixels drop the NW read and skip ahead.
      RD_NW: begin res_rd = |res_di; nxt = |res_di ? RD_N : NXT; end
      RD_N:  begin res_rd = 1'b1; nxt = RD_NE; end
      RD_NE: begin res_rd = 1'b1; nxt = RD_W; end
      RD_W:  begin res_rd = 1'b1; nxt = CMP; end
      CMP:   nxt = WR;
      WR:    begin res_wr = 1'b1; res_do = m + 1'b1; nxt = NXT; end
      NXT:   nxt = last ? DONE : RD_C;
      DONE:  nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
`ifdef DT_FWD_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) obj_cnt <= '0;
    else if (state == WR) obj_cnt <= obj_cnt + 1'b1;
  end
`endif
endmodule
